mem_responder: RTL and testbench

Memory-side responder for the multicycle core's memory strobes (`mem_read`, `mem_write`, address selected by `iord`). It accepts one read or write request at a time, models a fixed access latency with a wait-state counter, and completes each transfer with a four-phase `ready` handshake. The control unit holds its strobe until `ready` is returned, which gives the core a stall point. The block sits between the datapath address/data muxes and the unified instruction/data store.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle core. It accepts one read or
//   write request at a time and inserts WAIT_CYCLES wait states. It then
//   performs the array access and holds `ready` until the control unit
//   drops both strobes. The control unit uses this as a four-phase stall
//   point.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   mem_read   read request strobe (level)
//   mem_write  write request strobe (level)
//   addr       word address, sampled at accept
//   wdata      write data, sampled at accept
//   rdata      registered read data, meaningful while ready=1 after a read
//   ready      transfer complete, held until both strobes are low
//   err        request rejected (illegal and/or out of range), valid with ready
//   busy       high while a request is in flight or being acknowledged
//
// Configuration macro
//   MEM_RESP_ADDR_CHECK_EN  when defined, addr >= DEPTH is rejected with err.
//                           When undefined, the index is addr modulo DEPTH,
//                           so DEPTH must be a power of two.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_q;
  logic               bad_q;
  logic               oor;
  logic               access;

  logic [DATA_W-1:0]  mem [DEPTH];

`ifdef MEM_RESP_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  assign oor = ({1'b0, addr} >= DEPTH_X);
`else
  // Upper address bits alias onto the array; only the low bits are used.
  logic addr_unused;
  assign addr_unused = ^addr;
  assign oor = 1'b0;
`endif

  // The access edge is the WAIT edge that sees the counter at zero. This
  // places it at accept+WAIT_CYCLES+1 for every setting. WAIT_CYCLES=0
  // therefore spends exactly one cycle in WAIT.
  assign access = (state == S_WAIT) && (cnt == 4'd0);

  // Array has no reset, so its contents survive reset. A reset on the
  // access edge suppresses the commit, which drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && access && wr_q && !bad_q)
      mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            idx_q   <= addr[IDX_W-1:0];
            wdata_q <= wdata;
            wr_q    <= mem_write && !mem_read;
            bad_q   <= (mem_read && mem_write) || oor;
            cnt     <= WAIT_LD;
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACK;
            ready <= 1'b1;
            err   <= bad_q;
            // A write response leaves rdata untouched.
            if (bad_q)      rdata <= '0;
            else if (!wr_q) rdata <= mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          // A strobe that is still held keeps us here without re-accepting.
          if (!mem_read && !mem_write) begin
            state <= S_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
`ifdef MEM_RESP_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rd [2];
  logic              wr [2];
  logic [ADDR_W-1:0] ad [2];
  logic [DATA_W-1:0] wd [2];
  logic [DATA_W-1:0] rdata_v [2];
  logic              ready_v [2];
  logic              err_v [2];
  logic              busy_v [2];

  int total = 0;
  int bad   = 0;

  // Reference contents per instance, keyed by array index.
  logic [DATA_W-1:0] model0 [int];
  logic [DATA_W-1:0] model1 [int];

  always #5 clk = ~clk;

  // Instance 0: two wait states. Instance 1: zero wait states.
  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rdata_v[0]), .ready(ready_v[0]),
    .err(err_v[0]), .busy(busy_v[0]));

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rdata_v[1]), .ready(ready_v[1]),
    .err(err_v[1]), .busy(busy_v[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk({tag, "_ready"}, 32'(ready_v[s]), 32'd0);
      chk({tag, "_err"},   32'(err_v[s]),   32'd0);
      chk({tag, "_busy"},  32'(busy_v[s]),  32'd0);
      chk({tag, "_rdata"}, 32'(rdata_v[s]), 32'd0);
    end
  endtask

  // One complete transfer; called and returning on a negedge.
  // hold: extra cycles the strobe stays high in ACK.
  // early: strobes drop right after accept.
  task automatic xfer(input int s, input bit r, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input int hold, input bit early);
    int n;
    int ix;
    bit e;
    logic [DATA_W-1:0] exp_rd;
    n  = (s == 0) ? 2 : 0;
    e  = (r && w) || (CHK && int'(a) >= DEPTH);
    ix = int'(a) % DEPTH;
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    @(posedge clk);
    @(negedge clk);
    // Post-accept changes must be ignored.
    ad[s] = ADDR_W'($urandom);
    wd[s] = DATA_W'($urandom);
    if (early) begin rd[s] = 1'b0; wr[s] = 1'b0; end
    for (int j = 0; j <= n; j++) begin
      chk("lat_ready", 32'(ready_v[s]), 32'd0);
      chk("lat_busy",  32'(busy_v[s]),  32'd1);
      @(negedge clk);
    end
    chk("ack_ready", 32'(ready_v[s]), 32'd1);
    chk("ack_busy",  32'(busy_v[s]),  32'd1);
    chk("ack_err",   32'(err_v[s]),   32'(e));
    if (e) begin
      chk("ack_rdata_err", 32'(rdata_v[s]), 32'd0);
    end else if (r) begin
      exp_rd = (s == 0) ? model0[ix] : model1[ix];
      chk("ack_rdata", 32'(rdata_v[s]), 32'(exp_rd));
    end else begin
      if (s == 0) model0[ix] = d; else model1[ix] = d;
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_ready", 32'(ready_v[s]), 32'd1);
      end
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(ready_v[s]), 32'd0);
    chk("rel_busy",  32'(busy_v[s]),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] pool [8];
    logic [DATA_W-1:0] keep;
    pool = '{12'h011, 12'h2A5, 12'h3FF, 12'h100, 12'h400, 12'h7FF, 12'h5A0, 12'h0F0};
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    // Write/read, latency 3 cycles after accept on instance 0.
    xfer(0, 1'b0, 1'b1, 12'h010, 16'hBEEF, 0, 1'b0);
    xfer(0, 1'b1, 1'b0, 12'h010, 16'h0000, 0, 1'b0);
    chk("beef", 32'(rdata_v[0]), 32'h0000BEEF);

    // Memory survives reset.
    reset = 1'b1;
    @(negedge clk);
    chk_idle("reset2");
    reset = 1'b0;
    xfer(0, 1'b1, 1'b0, 12'h010, 16'h0000, 0, 1'b0);
    chk("beef_after_reset", 32'(rdata_v[0]), 32'h0000BEEF);

    // Zero wait states, strobe held 5 cycles.
    xfer(1, 1'b0, 1'b1, 12'h020, 16'hC0DE, 0, 1'b0);
    xfer(1, 1'b1, 1'b0, 12'h020, 16'h0000, 4, 1'b0);
    chk("held_read", 32'(rdata_v[1]), 32'h0000C0DE);

    // Illegal request leaves the array alone.
    xfer(0, 1'b0, 1'b1, 12'h030, 16'h1234, 0, 1'b0);
    xfer(0, 1'b1, 1'b1, 12'h030, 16'hFFFF, 0, 1'b0);
    xfer(0, 1'b1, 1'b0, 12'h030, 16'h0000, 0, 1'b0);
    chk("after_illegal", 32'(rdata_v[0]), 32'h00001234);

    // Strobe dropped during WAIT still completes.
    xfer(0, 1'b1, 1'b0, 12'h030, 16'h0000, 0, 1'b1);

    // Reset in the second WAIT cycle drops the pending write.
    xfer(0, 1'b0, 1'b1, 12'h040, 16'h1111, 0, 1'b0);
    wr[0] = 1'b1; ad[0] = 12'h040; wd[0] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr[0] = 1'b0;
    chk_idle("mid_reset");
    reset = 1'b0;
    xfer(0, 1'b1, 1'b0, 12'h040, 16'h0000, 0, 1'b0);
    chk("dropped_write", 32'(rdata_v[0]), 32'h00001111);

    // Address beyond DEPTH: rejected or aliased to index 0.
    xfer(0, 1'b0, 1'b1, 12'h000, 16'hAAAA, 0, 1'b0);
    xfer(0, 1'b0, 1'b1, 12'h400, 16'h7777, 0, 1'b0);
    xfer(0, 1'b1, 1'b0, 12'h000, 16'h0000, 0, 1'b0);
    keep = CHK ? 16'hAAAA : 16'h7777;
    chk("alias", 32'(rdata_v[0]), 32'(keep));

    // Randomised traffic over a small address pool on both instances.
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 8; p++)
        xfer(s, 1'b0, 1'b1, pool[p], DATA_W'($urandom), 0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      int s;
      int op;
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      xfer(s, (op == 0) || (op > 4), (op <= 4), pool[$urandom_range(0, 7)],
           DATA_W'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
